// File: rtl/alu_pkg.sv
// Shared ALU definitions: data-width default, opcode type/encodings and the
// stored flag record used by the result buffer.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  typedef logic [3:0] alu_opcode_t;

  localparam alu_opcode_t OP_NOP = 4'h0;
  localparam alu_opcode_t OP_ADD = 4'h1;
  localparam alu_opcode_t OP_SUB = 4'h2;
  localparam alu_opcode_t OP_AND = 4'h3;
  localparam alu_opcode_t OP_OR  = 4'h4;
  localparam alu_opcode_t OP_XOR = 4'h5;
  localparam alu_opcode_t OP_SHL = 4'h6;
  localparam alu_opcode_t OP_SHR = 4'h7;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
  } alu_flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag derivation from a DATA_W+1 bit ALU result whose MSB is
// the carry/borrow.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [DATA_W:0] result,
  output logic            carry,
  output logic            zero,
  output logic            negative
);

  assign carry    = result[DATA_W];
  assign zero     = (result[DATA_W-1:0] == '0);
  assign negative = result[DATA_W-1];

endmodule

// File: rtl/alu_result_buffer.sv
// FIFO of ALU results with flags captured at push time. Defining
// ALU_RESULT_STATS_EN adds saturating carry-push and input-stall counters.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W:0]          in_result,
  input  alu_opcode_t              in_opcode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output alu_opcode_t              out_opcode,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_negative,
  output logic [$clog2(DEPTH):0]   count
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [15:0]              stat_carry_cnt,
  output logic [15:0]              stat_stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] data_q  [DEPTH];
  alu_opcode_t       op_q    [DEPTH];
  alu_flags_t        flags_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic       full, empty, push, pop;
  alu_flags_t new_flags;

  alu_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
    .result   (in_result),
    .carry    (new_flags.carry),
    .zero     (new_flags.zero),
    .negative (new_flags.negative)
  );

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // A full buffer refuses pushes even when the head is popped the same edge.
  assign push  = in_valid && !full;
  assign pop   = out_ready && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; empty-gating below hides stale contents.
  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      data_q[wr_ptr_q]  <= in_result[DATA_W-1:0];
      op_q[wr_ptr_q]    <= in_opcode;
      flags_q[wr_ptr_q] <= new_flags;
    end
  end

  assign in_ready     = !full;
  assign out_valid    = !empty;
  assign out_data     = empty ? '0 : data_q[rd_ptr_q];
  assign out_opcode   = empty ? '0 : op_q[rd_ptr_q];
  assign out_carry    = !empty && flags_q[rd_ptr_q].carry;
  assign out_zero     = !empty && flags_q[rd_ptr_q].zero;
  assign out_negative = !empty && flags_q[rd_ptr_q].negative;
  assign count        = count_q;

`ifdef ALU_RESULT_STATS_EN
  logic [15:0] carry_cnt_q, stall_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      carry_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push && new_flags.carry && carry_cnt_q != 16'hFFFF)
        carry_cnt_q <= carry_cnt_q + 16'd1;
      if (in_valid && full && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stat_carry_cnt = carry_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entry count (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 32, meaning ALU data width; the result input is DATA_W+1 bits wide.
REQ-003 SHALL have one clock with a synchronous, active-low reset: clock  input  1  rising-edge clock.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  ALU result present.
REQ-006 in_ready  output  1  buffer accepts; equals !full.
REQ-007 in_result  input  DATA_W+1  ALU result; MSB is carry/borrow.
REQ-008 in_opcode  input  4  opcode that produced in_result.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  consumer takes head.
REQ-011 out_data  output  DATA_W  head result, low DATA_W bits.
REQ-012 out_opcode  output  4  head opcode.
REQ-013 out_carry, out_zero, out_negative  output  1 each  head flags.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Push SHALL occur on a rising edge with in_valid && in_ready; pop SHALL occur with out_valid && out_ready.
REQ-016 Flags SHALL be computed at push and stored: carry = in_result[DATA_W], zero = (in_result[DATA_W-1:0] == 0), negative = in_result[DATA_W-1].
REQ-017 Latency SHALL be one cycle: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N; no combinational in-to-out bypass.
REQ-018 out_* SHALL be driven from the entry at the read pointer; when empty, out_valid=0 and out_data, out_opcode, and flags are 0.
REQ-019 Full (count==DEPTH): in_ready=0; in_valid is ignored; no push even when a pop occurs that cycle.
REQ-020 Empty (count==0): out_valid=0; out_ready is ignored.
REQ-021 Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance.
REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-023 in_valid/in_result SHALL be sampled only at the push edge; upstream holds them while in_ready=0.

Reset
REQ-024 With reset_n=0 at a rising edge: pointers and count = 0, in_ready=1 on the next cycle, and out_valid, out_data, out_opcode, and flags = 0.
REQ-025 Reset mid-operation SHALL discard all stored entries; storage array contents need not be cleared.

Configuration
REQ-026 Macro ALU_RESULT_STATS_EN defined: SHALL add outputs stat_carry_cnt[15:0] (pushes with carry=1) and stat_stall_cnt[15:0] (cycles with in_valid && !in_ready); both saturate at 16'hFFFF and reset to 0.
REQ-027 Macro undefined: the stat ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-028 Opcode localparams, the 4-bit opcode typedef, and the DATA_W default SHALL reside in the shared package alu_pkg.
REQ-029 Flag derivation SHALL be a combinational sub-module alu_flag_gen (in: result DATA_W+1; out: carry, zero, negative).
REQ-030 Storage SHALL be a register array inside alu_result_buffer; no vendor macros.

Verification
REQ-031 After reset, push in_result=33'h0_0000_0028 with opcode 4'b0001 -> next cycle out_valid=1, out_data=40, zero=0, carry=0, negative=0, count=1.
REQ-032 Push 33'h1_0000_0000 -> out_data=0, zero=1, carry=1; push 33'h0_8000_0000 -> negative=1, carry=0.
REQ-033 With out_ready=0, push 5 results at DEPTH=4 -> in_ready=0 after the 4th push, the 5th is not accepted, and count=4; then out_ready=1 -> the 4 values drain in order and count reaches 0.
REQ-034 At count=2, push and pop on the same edge for 10 cycles -> count stays 2 and the output order matches the input order across pointer wrap.
REQ-035 Assert reset_n=0 at count=3 -> next cycle count=0, out_valid=0, in_ready=1, and the old entries never appear.
REQ-036 With ALU_RESULT_STATS_EN defined: 3 carry pushes and 5 full-stall cycles -> stat_carry_cnt=3 and stat_stall_cnt=5.
